// File: rtl/key_uart_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | key_uart_pkg : key codes, ASCII constants and serialiser state encoding    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package key_uart_pkg;

    localparam logic [3:0] KEY_S1   = 4'b0001;
    localparam logic [3:0] KEY_S2   = 4'b0010;
    localparam logic [3:0] KEY_S3   = 4'b0100;
    localparam logic [3:0] KEY_S4   = 4'b1000;
    localparam logic [3:0] KEY_NONE = 4'b1111;

    localparam logic [7:0] ASCII_BASE = 8'h30;
    localparam logic [7:0] ASCII_CR   = 8'h0D;
    localparam logic [7:0] ASCII_LF   = 8'h0A;

    localparam int unsigned TX_STATE_W = 2;
    localparam logic [TX_STATE_W-1:0] ST_IDLE  = 2'd0;
    localparam logic [TX_STATE_W-1:0] ST_START = 2'd1;
    localparam logic [TX_STATE_W-1:0] ST_DATA  = 2'd2;
    localparam logic [TX_STATE_W-1:0] ST_STOP  = 2'd3;

    // Only exact one-hot codes count; idle, all-zero and multi-key codes are noise.
    function automatic logic key_is_event(input logic [3:0] code);
        case (code)
            KEY_S1, KEY_S2, KEY_S3, KEY_S4: return 1'b1;
            default:                        return 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] key_index(input logic [3:0] code);
        case (code)
            KEY_S2:  return 2'd1;
            KEY_S3:  return 2'd2;
            KEY_S4:  return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    function automatic logic [7:0] key_ascii(input logic [1:0] idx);
        return ASCII_BASE + {6'd0, idx} + 8'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_core.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | uart_tx_core : 8N1 byte serialiser with load/ready handshake               |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module uart_tx_core
    import key_uart_pkg::*;
#(
    parameter int BAUD_DIV = 434
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_load,
    input  logic [7:0] i_data,
    output logic       o_ready,
    output logic       o_busy,
    output logic       o_txd
);

    localparam int CNT_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);

    logic [TX_STATE_W-1:0] state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [2:0]            bit_q, bit_d;
    logic [7:0]            shift_q, shift_d;
    logic                  bit_end;

    assign bit_end = (cnt_q == CNT_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (i_load) begin
                    state_d = ST_START;
                    shift_d = i_data;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    state_d = ST_DATA;
                    cnt_d   = '0;
                    bit_d   = '0;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            ST_STOP: begin
                // A pending byte chains straight into its start bit, no idle gap.
                if (bit_end) begin
                    cnt_d = '0;
                    if (i_load) begin
                        state_d = ST_START;
                        shift_d = i_data;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        o_txd   = 1'b1;
        o_ready = 1'b0;
        o_busy  = 1'b1;
        case (state_q)
            ST_IDLE: begin
                o_ready = 1'b1;
                o_busy  = 1'b0;
            end
            ST_START: o_txd   = 1'b0;
            ST_DATA:  o_txd   = shift_q[0];
            ST_STOP:  o_ready = bit_end;
            default:  o_busy  = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/key_uart_tx.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | key_uart_tx : queues one-hot key events and sends them as ASCII over UART  |
// | Optional KEY_UART_CRLF_EN: append CR LF after every digit.  Rev 1.0        |
// +----------------------------------------------------------------------------+
module key_uart_tx
    import key_uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       uart_clk,
    input  logic       uart_rst,
    input  logic [3:0] key_value,
    output logic       uart_txd,
    output logic       tx_busy,
    output logic       ovf
);

    localparam int BAUD_DIV = CLK_FREQ / BAUD;
    localparam int ADDR_W   = $clog2(FIFO_DEPTH);
    localparam int PTR_W    = ADDR_W + 1;

    logic [1:0]       mem_q [FIFO_DEPTH];
    logic [1:0]       mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic             key_valid, fifo_empty, fifo_full, push, pop;
    logic             core_load, core_ready, core_busy;
    logic [1:0]       head_idx;
    logic [7:0]       core_data;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                        (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
    assign head_idx   = mem_q[rd_ptr_q[ADDR_W-1:0]];
    assign tx_busy    = core_busy | ~fifo_empty;

    // A pop in the same cycle frees the slot, so a write into a full queue still lands.
    always_comb begin
        key_valid = key_is_event(key_value);
        push      = key_valid && (!fifo_full || pop);
        ovf       = key_valid && fifo_full && !pop;
        wr_ptr_d  = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d  = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        mem_d     = mem_q;
        if (push) begin
            mem_d[wr_ptr_q[ADDR_W-1:0]] = key_index(key_value);
        end
    end

    always_ff @(posedge uart_clk) begin
        if (!uart_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge uart_clk) begin
        mem_q <= mem_d;
    end

`ifdef KEY_UART_CRLF_EN
    logic [1:0] byte_sel_q, byte_sel_d;

    always_ff @(posedge uart_clk) begin
        if (!uart_rst) begin
            byte_sel_q <= 2'd0;
        end else begin
            byte_sel_q <= byte_sel_d;
        end
    end

    // The queue entry is consumed with the digit; CR and LF follow from byte_sel.
    always_comb begin
        pop        = 1'b0;
        core_load  = 1'b0;
        core_data  = key_ascii(head_idx);
        byte_sel_d = byte_sel_q;
        if (core_ready) begin
            case (byte_sel_q)
                2'd1: begin
                    core_load  = 1'b1;
                    core_data  = ASCII_CR;
                    byte_sel_d = 2'd2;
                end
                2'd2: begin
                    core_load  = 1'b1;
                    core_data  = ASCII_LF;
                    byte_sel_d = 2'd0;
                end
                default: begin
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        core_load  = 1'b1;
                        byte_sel_d = 2'd1;
                    end
                end
            endcase
        end
    end
`else
    always_comb begin
        pop       = core_ready && !fifo_empty;
        core_load = pop;
        core_data = key_ascii(head_idx);
    end
`endif

    uart_tx_core #(
        .BAUD_DIV (BAUD_DIV)
    ) u_core (
        .clk     (uart_clk),
        .rst_n   (uart_rst),
        .i_load  (core_load),
        .i_data  (core_data),
        .o_ready (core_ready),
        .o_busy  (core_busy),
        .o_txd   (uart_txd)
    );

endmodule
`default_nettype wire
